disp_writer: RTL and testbench
==============================

# disp_writer

Converts a 27-bit unsigned binary result into eight decimal digits and writes them, one per cycle, onto the `dig`/`pos` digit-write bus that feeds the 8-digit seven-segment display controller. It sits between the calculator datapath (result + `start` strobe) and the display controller. Conversion uses iterative double-dabble. Idle and skipped cycles drive an out-of-range position, so the controller ignores the bus.

## Interface
- `NDIG`, 8, number of display digits; fixed at 8 (width of `pos` and BCD shift register derive from it)
- `VW`, 27, binary input width; 27 bits covers 99_999_999
- `clock`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  request conversion of `value`; sampled only in IDLE
- `value`  in  27  unsigned binary result; captured on the accepted `start` edge
- `dig`  out  4  BCD digit to write; 4'hF when not writing
- `pos`  out  4  target digit position 0..7 (0 = least significant); 4'hF when not writing
- `busy`  out  1  high from accepted `start` until `done`, inclusive of CONV/WRITE
- `done`  out  1  one-cycle pulse after last write slot
- `ovf`  out  1  latched high if captured `value` > 99_999_999; cleared on next accepted `start`

## Operation
- Reset (async, any state): state=IDLE; `dig`=4'hF, `pos`=4'hF, `busy`=0, `done`=0, `ovf`=0; shift registers and counters cleared.
- IDLE: `start`=1 at a rising edge → capture `value`, set `ovf`, clear BCD register (32 bits), load iteration counter=0, go CONV, `busy`=1.
- Overflow: if captured `value` > 99_999_999, substitute 99_999_999 before conversion (all digits 9), `ovf`=1.
- CONV: 27 cycles; each cycle add 3 to every BCD nibble ≥5, then shift {BCD, bin} left by one. After iteration 27 → WRITE, slot=0.
- WRITE: 8 cycles, slot 0..7; registered outputs `pos`=slot, `dig`=BCD nibble[slot]. After slot 7 → DONE.
- DONE: `done`=1, `busy`=0, `dig`/`pos`=4'hF for one cycle → IDLE.
- `start` outside IDLE (including the DONE cycle) ignored; `value` changes after capture have no effect.
- All written digits are 0..9 and all positions are 0..7, so every WRITE slot is a valid write.

## Timing
- Edge E0: `start` accepted. `busy` is high after E0.
- CONV occupies cycles following E0 through E27.
- First write (`pos`=0) visible after E28; `pos`=7 after E35.
- `done` high after E36 for exactly one cycle. IDLE after E37; next `start` accepted at E37 earliest.
- Fixed latency: 36 cycles from `start` edge to `done`, independent of value and configuration.
- Outputs are registered; no combinational path from `start`/`value` to any output.
- Reset asserted mid-CONV/WRITE: outputs return to sentinel immediately; any partial display update is not resumed.

## Configuration
- `WRITE_CACHE_EN` defined: an 8×4 shadow register holds the last digit written per position (reset value 0, matching the display controller reset). In WRITE, a slot whose digit equals its shadow entry drives `pos`=4'hF and `dig`=4'hF (no write). Written slots update the shadow. Slot count and latency are unchanged.
- Not defined: no shadow register; every slot writes unconditionally.

## Test plan
- `value`=12_345_678, `start` pulse → `pos`/`dig` (0,8),(1,7),(2,6),(3,5),(4,4),(5,3),(6,2),(7,1) on E28..E35 edges; `done` after E36; `ovf`=0.
- `value`=0 → eight writes of `dig`=0 at `pos` 0..7 (cache off). With cache on, after reset, all slots are `pos`=4'hF.
- `value`=123_456_789 → `ovf`=1; all eight digits 9; next `start` with `value`=5 → `ovf`=0, digits 5,0,0,0,0,0,0,0.
- `start` held high continuously with `value`=42 → conversions accepted at E0, E37, E74 only; `busy` low only on DONE cycles.
- Reset asserted after `pos`=3 write → `dig`=`pos`=4'hF, `busy`=0 same cycle; no further writes; new `start` behaves normally.
- `WRITE_CACHE_EN`: write 12_345_678 then 12_345_699 → second pass writes only `pos` 0 (`dig`=9) and `pos` 1 (`dig`=9); others 4'hF; `done` is still at +36.

Source files
------------

// File: rtl/disp_writer.sv
// Binary-to-BCD display writer: iterative double-dabble, then one digit write per cycle.
// Optional WRITE_CACHE_EN macro enables a per-position shadow that suppresses redundant writes.
module disp_writer #(
  parameter int NDIG = 8,
  parameter int VW   = 27
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [VW-1:0] value,
  output logic [3:0]    dig,
  output logic [3:0]    pos,
  output logic          busy,
  output logic          done,
  output logic          ovf
);

  localparam int BW = 4 * NDIG;
  localparam int IW = $clog2(VW);
  localparam int SW = $clog2(NDIG);
  localparam logic [VW-1:0] MAXV = VW'(99_999_999);
  localparam logic [3:0]    NOWR = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_WRITE,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [VW-1:0] r_bin;
  logic [BW-1:0] r_bcd;
  logic [BW-1:0] w_bcd_adj;
  logic [IW-1:0] r_iter;
  logic [SW-1:0] r_slot;
  logic [3:0]    w_slot_dig;
  logic          w_skip;
  logic          w_ovf;
  logic [3:0]    r_dig;
  logic [3:0]    r_pos;
  logic          r_busy;
  logic          r_done;
  logic          r_ovf;

  assign dig  = r_dig;
  assign pos  = r_pos;
  assign busy = r_busy;
  assign done = r_done;
  assign ovf  = r_ovf;

  assign w_ovf      = (value > MAXV);
  assign w_slot_dig = r_bcd[{r_slot, 2'b00} +: 4];

  // Double-dabble correction: any nibble >= 5 gets +3 before the shift.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) begin
        w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
    end
  end

`ifdef WRITE_CACHE_EN
  logic [3:0] r_shadow [NDIG];

  assign w_skip = (r_shadow[r_slot] == w_slot_dig);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NDIG; i++) begin
        r_shadow[i] <= '0;
      end
    end else if (r_state == S_WRITE && !w_skip) begin
      r_shadow[r_slot] <= w_slot_dig;
    end
  end
`else
  assign w_skip = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_CONV;
      S_CONV:  if (r_iter == IW'(VW - 1)) w_state_nxt = S_WRITE;
      S_WRITE: if (r_slot == SW'(NDIG - 1)) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // DONE is the cycle the last write is on the bus; the done pulse is
  // registered out of it, so IDLE coincides with the visible done cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_bin  <= '0;
      r_bcd  <= '0;
      r_iter <= '0;
      r_slot <= '0;
      r_dig  <= NOWR;
      r_pos  <= NOWR;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_dig  <= NOWR;
          r_pos  <= NOWR;
          r_done <= 1'b0;
          if (start) begin
            r_bin  <= w_ovf ? MAXV : value;
            r_ovf  <= w_ovf;
            r_bcd  <= '0;
            r_iter <= '0;
            r_busy <= 1'b1;
          end
        end
        S_CONV: begin
          r_bcd  <= {w_bcd_adj[BW-2:0], r_bin[VW-1]};
          r_bin  <= {r_bin[VW-2:0], 1'b0};
          r_iter <= r_iter + IW'(1);
          r_slot <= '0;
        end
        S_WRITE: begin
          if (w_skip) begin
            r_dig <= NOWR;
            r_pos <= NOWR;
          end else begin
            r_dig <= w_slot_dig;
            r_pos <= 4'(r_slot);
          end
          r_slot <= r_slot + SW'(1);
        end
        S_DONE: begin
          r_dig  <= NOWR;
          r_pos  <= NOWR;
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
        default: begin
          r_dig <= NOWR;
          r_pos <= NOWR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_disp_writer.sv
// Self-checking bench for disp_writer: directed and random conversions against a
// decimal-arithmetic reference model, held start, and mid-write reset.
module tb_disp_writer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [26:0] value;
  logic [3:0]  dig;
  logic [3:0]  pos;
  logic        busy;
  logic        done;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  logic [3:0] shadow [8];

`ifdef WRITE_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  always #5 clock = ~clock;

  disp_writer #(.NDIG(8), .VW(27)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .value(value),
    .dig  (dig),
    .pos  (pos),
    .busy (busy),
    .done (done),
    .ovf  (ovf)
  );

  function automatic int ref_digit(input longint v, input int i);
    longint x;
    x = (v > 99999999) ? 99999999 : v;
    for (int k = 0; k < i; k++) x = x / 10;
    return int'(x % 10);
  endfunction

  // Expected bus contents for one write slot; tracks what the display already holds.
  task automatic model_slot(input logic [26:0] v, input int s, output logic [3:0] ep, output logic [3:0] ed);
    logic [3:0] d;
    d = 4'(ref_digit(longint'(v), s));
    if (CACHE && shadow[s] == d) begin
      ep = 4'hF;
      ed = 4'hF;
    end else begin
      ep = 4'(s);
      ed = d;
      shadow[s] = d;
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic clear_shadow;
    for (int i = 0; i < 8; i++) shadow[i] = 4'h0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    value = '0;
    clear_shadow();
    tick();
    tick();
    checks++;
    if (dig !== 4'hF || pos !== 4'hF || busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: dig=%h pos=%h busy=%b done=%b ovf=%b, want F F 0 0 0", dig, pos, busy, done, ovf);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_conversion(input logic [26:0] v, input string tag);
    logic [3:0] ep, ed;
    logic       eovf;
    eovf  = (v > 27'd99999999);
    value = v;
    start = 1'b1;
    tick();
    start = 1'b0;
    value = 27'($urandom);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || pos !== 4'hF || ovf !== eovf) begin
      errors++;
      $display("FAIL %s_accept: busy=%b done=%b pos=%h ovf=%b, want 1 0 F %b", tag, busy, done, pos, ovf, eovf);
    end
    for (int n = 1; n <= 27; n++) begin
      tick();
      checks++;
      if (pos !== 4'hF || dig !== 4'hF || busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL %s_conv E%0d: pos=%h dig=%h busy=%b done=%b, want F F 1 0", tag, n, pos, dig, busy, done);
      end
    end
    for (int s = 0; s < 8; s++) begin
      tick();
      model_slot(v, s, ep, ed);
      checks++;
      if (pos !== ep || dig !== ed || busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL %s_write slot%0d: pos=%h dig=%h busy=%b done=%b, want %h %h 1 0", tag, s, pos, dig, busy, done, ep, ed);
      end
    end
    tick();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || pos !== 4'hF || dig !== 4'hF || ovf !== eovf) begin
      errors++;
      $display("FAIL %s_done: done=%b busy=%b pos=%h dig=%h ovf=%b, want 1 0 F F %b", tag, done, busy, pos, dig, ovf, eovf);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || pos !== 4'hF) begin
      errors++;
      $display("FAIL %s_idle: done=%b busy=%b pos=%h, want 0 0 F", tag, done, busy, pos);
    end
  endtask

  task automatic test_random;
    logic [26:0] v;
    for (int r = 0; r < 8; r++) begin
      if (r % 3 == 2) v = 27'($urandom);
      else            v = 27'($urandom_range(0, 99999999));
      test_conversion(v, "random");
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] ep, ed;
    int         p;
    value = 27'd42;
    start = 1'b1;
    tick();
    for (int n = 1; n <= 110; n++) begin
      tick();
      p = n % 37;
      checks++;
      if (busy !== (p != 36) || done !== (p == 36)) begin
        errors++;
        $display("FAIL held_start E%0d: busy=%b done=%b, want %b %b", n, busy, done, (p != 36), (p == 36));
      end
      if (p >= 28 && p <= 35) begin
        model_slot(27'd42, p - 28, ep, ed);
        checks++;
        if (pos !== ep || dig !== ed) begin
          errors++;
          $display("FAIL held_write E%0d: pos=%h dig=%h, want %h %h", n, pos, dig, ep, ed);
        end
      end
    end
    start = 1'b0;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL held_release: busy=%b done=%b ovf=%b, want 0 0 0", busy, done, ovf);
    end
  endtask

  task automatic test_reset_mid;
    logic [3:0]  ep, ed;
    logic [26:0] v;
    v     = 27'($urandom_range(0, 99999999));
    value = v;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 31; n++) tick();
    for (int s = 0; s < 4; s++) model_slot(v, s, ep, ed);
    checks++;
    if (pos !== ep || dig !== ed) begin
      errors++;
      $display("FAIL midreset_slot3: pos=%h dig=%h, want %h %h", pos, dig, ep, ed);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (pos !== 4'hF || dig !== 4'hF || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL midreset_async: pos=%h dig=%h busy=%b done=%b, want F F 0 0", pos, dig, busy, done);
    end
    tick();
    reset = 1'b0;
    clear_shadow();
    for (int n = 0; n < 10; n++) begin
      tick();
      checks++;
      if (pos !== 4'hF || busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL midreset_quiet c%0d: pos=%h busy=%b done=%b, want F 0 0", n, pos, busy, done);
      end
    end
    test_conversion(27'd87654321, "after_reset");
  endtask

  initial begin
    test_reset();
    test_conversion(27'd0, "zero");
    test_conversion(27'd12345678, "dir12345678");
    test_conversion(27'd123456789, "overflow");
    test_conversion(27'd5, "five");
    test_conversion(27'd12345678, "cache_a");
    test_conversion(27'd12345699, "cache_b");
    test_conversion(27'd99999999, "max");
    test_conversion(27'h7FFFFFF, "allones");
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
